ps2_host_tx: RTL and testbench

Host-to-device transmitter for the PS/2 mouse port. It is the command path that complements the existing mouse receiver.
- Sends one byte per request (e.g. 0xFF reset, 0xF4 enable reporting, 0xF3 set sample rate) using the PS/2 request-to-send sequence.
- Checks the device ACK.
- Drives the shared PS2_CLK/PS2_DATA lines via open-drain enables. The top level maps oe=1 to 1'b0 and oe=0 to 1'bz.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_sync.sv | 33 +++
 rtl/ps2_host_tx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and
// frame bit positions, plus the odd-parity helper used by host and receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] PS2_ACK          = 8'hFA;

    // Frame positions counted in device clock falls after the clock is released.
    localparam logic [3:0] BIT_PARITY = 4'd9;
    localparam logic [3:0] BIT_STOP   = 4'd10;
    localparam logic [3:0] BIT_ACK    = 4'd11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a registered falling-edge
// detector; shared by the host transmitter and the mouse receiver.
module ps2_line_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // NOTE: the chain resets to the idle-high line level so leaving reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= line_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter with open-drain enables and ACK check.
// Define PS2_TX_RETRY_EN to retry a byte once after a NACK or timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int REQ_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST     = CNT_W'(REQ_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e    state;
    logic [CNT_W-1:0] cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       bit_n;
    logic [3:0]       next_n;
    logic [7:0]       data_q;
    logic             par_q;

    logic sync_clk;
    logic sync_data;
    logic clk_fall;
    logic data_fall_unused;

    logic accept;
    logic timeout_hit;
    logic ack_slot;
    logic fail;
    logic retry_ok;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_clk_in),
        .level   (sync_clk),
        .fall    (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_data_in),
        .level   (sync_data),
        .fall    (data_fall_unused)
    );

    assign accept      = tx_valid & tx_ready;
    assign next_n      = bit_n + 4'd1;
    assign timeout_hit = ((state == SHIFT) || (state == WAIT_IDLE)) && (to_cnt == TO_LAST);
    assign ack_slot    = (state == SHIFT) && clk_fall && (next_n == BIT_ACK);
    // Timeout wins over a same-cycle clock fall, so it is folded in unconditionally.
    assign fail        = timeout_hit | (ack_slot & sync_data);
    assign busy        = ~tx_ready;

`ifdef PS2_TX_RETRY_EN
    logic retried;

    always_ff @(posedge clk) begin
        if (rst) begin
            retried <= 1'b0;
        end else if (accept) begin
            retried <= 1'b0;
        end else if (fail) begin
            retried <= 1'b1;
        end
    end

    assign retry_ok = ~retried;
`else
    assign retry_ok = 1'b0;
`endif

    // NOTE: all state and outputs use non-blocking assignment; tx_done/tx_err default low each cycle to form single pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            cnt         <= '0;
            to_cnt      <= '0;
            bit_n       <= '0;
            data_q      <= '0;
            par_q       <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q     <= tx_data;
                        par_q      <= odd_parity(tx_data);
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        state      <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (cnt == INHIBIT_LAST) begin
                        cnt         <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                REQ: begin
                    if (cnt == REQ_LAST) begin
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b0;
                        bit_n      <= '0;
                        to_cnt     <= '0;
                        state      <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                SHIFT, WAIT_IDLE: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (fail) begin
                        ps2_data_oe <= 1'b0;
                        if (retry_ok) begin
                            ps2_clk_oe <= 1'b1;
                            cnt        <= '0;
                            state      <= INHIBIT;
                        end else begin
                            tx_err <= 1'b1;
                            state  <= ERR;
                        end
                    end else if (state == WAIT_IDLE) begin
                        if (sync_clk && sync_data) begin
                            tx_done <= 1'b1;
                            state   <= DONE;
                        end
                    end else if (clk_fall) begin
                        // Data changes while the device holds the clock low.
                        bit_n <= next_n;
                        if (next_n <= 4'd8) begin
                            ps2_data_oe <= ~data_q[bit_n[2:0]];
                        end else if (next_n == BIT_PARITY) begin
                            ps2_data_oe <= ~par_q;
                        end else if (next_n == BIT_STOP) begin
                            ps2_data_oe <= 1'b0;
                        end else if (next_n == BIT_ACK) begin
                            state <= WAIT_IDLE;
                        end
                    end
                end

                DONE, ERR: begin
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready    <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: wired-AND bus with a behavioural PS/2
// device, table-driven and random byte sends, plus reset, timeout and hold cases.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT = 40;
    localparam int REQ     = 10;
    localparam int TIMEOUT = 3000;
    localparam int HP      = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_err, busy;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit overlap_seen = 1'b0;
    bit idle_data_seen = 1'b0;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_err === 1'b1) err_cnt++;
        if (tx_done === 1'b1 && tx_err === 1'b1) overlap_seen = 1'b1;
        if (tx_ready === 1'b1 && ps2_data_oe === 1'b1) idle_data_seen = 1'b1;
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        done_cnt = 0;
        err_cnt  = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Counts negedges with clk_oe / data_oe high, ending at the first negedge after release.
    task automatic measure_request(output int ck, output int dt);
        int guard = 0;
        ck = 0;
        dt = 0;
        while (ps2_clk_oe !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        while (ps2_clk_oe === 1'b1 && guard < 5000) begin
            ck++;
            if (ps2_data_oe === 1'b1) dt++;
            @(negedge clk);
            guard++;
        end
    endtask

    // Device side: generates nclk clocks, reading the data line at each rising edge.
    task automatic dev_clock(input int nclk, input bit ack, output logic [9:0] bits, output logic start_bit);
        bits = '1;
        repeat (HP) @(negedge clk);
        start_bit = ps2_data_line;
        for (int i = 0; i < nclk && i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (HP) @(negedge clk);
            bits[i] = ps2_data_line;
            dev_clk_low = 1'b0;
            repeat (HP) @(negedge clk);
        end
        if (nclk > 10) begin
            if (ack) dev_data_low = 1'b1;
            repeat (HP / 2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HP) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HP / 2) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_outcome(input string tag, input int budget);
        int k = 0;
        while (done_cnt + err_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, " outcome_in_time"}, int'(k < budget), 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic run_txn(input string tag, input logic [7:0] d, input bit nack,
                           input logic exp_par, input bit exp_done);
        int ck, dt;
        logic [9:0] bits;
        logic start_bit;
        send_byte(d);
        measure_request(ck, dt);
        check({tag, " clk_oe_cycles"}, ck, INHIBIT + REQ);
        check({tag, " data_oe_cycles"}, dt, REQ);
        dev_clock(11, !nack, bits, start_bit);
        wait_outcome(tag, 1000);
        check({tag, " start_bit"}, int'(start_bit), 0);
        check({tag, " data_bits"}, int'(bits[7:0]), int'(d));
        check({tag, " parity_bit"}, int'(bits[8]), int'(exp_par));
        check({tag, " stop_bit"}, int'(bits[9]), 1);
        check({tag, " done_pulses"}, done_cnt, int'(exp_done));
        check({tag, " err_pulses"}, err_cnt, int'(!exp_done));
        check({tag, " ready_after"}, int'(tx_ready), 1);
        check({tag, " oe_released"}, int'({ps2_clk_oe, ps2_data_oe}), 0);
    endtask

    typedef struct {
        string      name;
        logic [7:0] data;
        bit         nack;
        logic       exp_par;
        bit         exp_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ck, dt, k;
        logic [9:0] bits;
        logic start_bit;
        logic [7:0] rd;
        bit rnack;

        vecs[0] = '{"enable_f4",   8'hF4, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{"reset_ff",    8'hFF, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{"rate_f3",     8'hF3, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{"nack_fa",     8'hFA, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{"nack_01",     8'h01, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{"zero_00",     8'h00, 1'b0, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset clk_oe", int'(ps2_clk_oe), 0);
        check("reset data_oe", int'(ps2_data_oe), 0);
        check("reset tx_ready", int'(tx_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset pulses", int'({tx_done, tx_err}), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        foreach (vecs[i])
            run_txn(vecs[i].name, vecs[i].data, vecs[i].nack, vecs[i].exp_par, vecs[i].exp_done);

        for (int i = 0; i < 6; i++) begin
            rd    = 8'($urandom);
            rnack = ($urandom_range(0, 3) == 0);
            run_txn($sformatf("rand%0d_%02h", i, rd), rd, rnack,
                    logic'(($countones(rd) % 2) == 0), !rnack);
        end

        // Reset after the 5th data bit has been put on the line.
        send_byte(8'hE0);
        measure_request(ck, dt);
        dev_clock(5, 1'b1, bits, start_bit);
        check("midrst data_oe_before", int'(ps2_data_oe), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst clk_oe", int'(ps2_clk_oe), 0);
        check("midrst data_oe", int'(ps2_data_oe), 0);
        check("midrst tx_ready", int'(tx_ready), 1);
        check("midrst pulses_now", int'({tx_done, tx_err}), 0);
        repeat (20) @(negedge clk);
        check("midrst pulses_later", done_cnt + err_cnt, 0);
        run_txn("after_rst_f3", 8'hF3, 1'b0, 1'b1, 1'b1);

        // tx_valid held with a different byte during an in-flight transfer.
        @(negedge clk);
        done_cnt = 0;
        err_cnt  = 0;
        tx_valid = 1'b1;
        tx_data  = 8'hF4;
        @(negedge clk);
        tx_data = 8'h00;
        measure_request(ck, dt);
        dev_clock(11, 1'b1, bits, start_bit);
        k = 0;
        while (done_cnt + err_cnt == 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("hold first_done", done_cnt, 1);
        check("hold first_bits", int'(bits[7:0]), 32'hF4);
        k = 0;
        while (ps2_clk_oe !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        tx_valid = 1'b0;
        check("hold second_accept", int'(ps2_clk_oe), 1);
        done_cnt = 0;
        err_cnt  = 0;
        measure_request(ck, dt);
        check("hold second_clk_oe_cycles", ck, INHIBIT + REQ);
        dev_clock(11, 1'b1, bits, start_bit);
        wait_outcome("hold second", 1000);
        check("hold second_bits", int'(bits[7:0]), 0);
        check("hold second_parity", int'(bits[8]), 1);
        check("hold second_done", done_cnt, 1);
        repeat (HP * 4) @(negedge clk);
        check("hold stays_idle", int'(tx_ready), 1);

        // Device never clocks: timeout measured from clock release.
        send_byte(8'hA5);
        measure_request(ck, dt);
`ifdef PS2_TX_RETRY_EN
        k = 0;
        while (ps2_clk_oe !== 1'b1 && tx_err !== 1'b1 && k < TIMEOUT + 50) begin
            @(negedge clk);
            k++;
        end
        check("timeout retry_reinhibit", int'(ps2_clk_oe), 1);
        check("timeout retry_latency", int'(k >= TIMEOUT - 3 && k <= TIMEOUT + 3), 1);
        check("timeout retry_no_err", err_cnt, 0);
        measure_request(ck, dt);
        check("timeout retry_clk_oe_cycles", ck, INHIBIT + REQ);
`endif
        k = 0;
        while (tx_err !== 1'b1 && k < TIMEOUT + 50) begin
            @(negedge clk);
            k++;
        end
        check("timeout err_latency", int'(k >= TIMEOUT - 3 && k <= TIMEOUT + 3), 1);
        check("timeout oe_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
        @(negedge clk);
        check("timeout tx_ready", int'(tx_ready), 1);
        repeat (3) @(negedge clk);
        check("timeout err_pulses", err_cnt, 1);
        check("timeout done_pulses", done_cnt, 0);

        check("no done_err_overlap", int'(overlap_seen), 0);
        check("no data_oe_in_idle", int'(idle_data_seen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, limit=900us");
        $fatal(1, "watchdog expired");
    end

endmodule
